// File: rtl/tile_draw_ctrl.sv
// Tile draw sequencer: walks every pixel of a 2^TB x 2^TB tile, reads its colour from a
// synchronous tile ROM and issues one plot write per opaque pixel to the frame buffer.
module tile_draw_ctrl #(
  parameter int TB    = 3,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int IW    = 4,
  parameter int CW    = 3,
  parameter int TRANS = 0
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic [XW-1:0]        TileX,
  input  logic [YW-1:0]        TileY,
  input  logic [IW-1:0]        TileIdx,
  input  logic                 Stall,
  output logic [IW+2*TB-1:0]   RomAddr,
  input  logic [CW-1:0]        RomData,
  output logic [XW-1:0]        PlotX,
  output logic [YW-1:0]        PlotY,
  output logic [CW-1:0]        PlotColour,
  output logic                 Plot,
  output logic                 Busy,
  output logic                 Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [TB-1:0] EDGE_MAX = '1;

  state_t          state_q, state_d;
  logic [XW-1:0]   tile_x_q;
  logic [YW-1:0]   tile_y_q;
  logic [IW-1:0]   tile_idx_q;
  logic [TB-1:0]   px_q, py_q;
  logic [TB-1:0]   s1_px_q, s1_py_q;
  logic            s1_valid_q;
  logic            s1_first_q;
  logic [CW-1:0]   hold_q;

  logic            accept;
  logic            advance;
  logic            last_pix;
  logic [CW-1:0]   colour;
  logic            plot;

  assign accept   = (state_q == S_IDLE) && Start;
  assign advance  = (state_q == S_FETCH) && (!s1_valid_q || !Stall);
  assign last_pix = (px_q == EDGE_MAX) && (py_q == EDGE_MAX);
  // ROM output only matches the pending pixel in its first cycle; afterwards use the copy.
  assign colour   = s1_first_q ? RomData : hold_q;
  assign plot     = s1_valid_q && !Stall && (colour != CW'(TRANS));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_FETCH;
      S_FETCH: if (advance && last_pix) state_d = S_DRAIN;
      S_DRAIN: if (!s1_valid_q || !Stall) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    RomAddr    = '0;
    Plot       = 1'b0;
    PlotX      = '0;
    PlotY      = '0;
    PlotColour = '0;
    case (state_q)
      S_FETCH: begin
        Busy    = 1'b1;
        RomAddr = {tile_idx_q, py_q, px_q};
      end
      S_DRAIN: Busy = 1'b1;
      S_DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
    if (plot) begin
      Plot       = 1'b1;
      PlotX      = tile_x_q + XW'(s1_px_q);
      PlotY      = tile_y_q + YW'(s1_py_q);
      PlotColour = colour;
    end
  end

  // Tile position/index registers load only on an accepted Start.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      tile_idx_q <= '0;
    end else if (accept) begin
      tile_x_q   <= TileX;
      tile_y_q   <= TileY;
      tile_idx_q <= TileIdx;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else if (accept) begin
      px_q <= '0;
      py_q <= '0;
    end else if (advance) begin
      px_q <= px_q + 1'b1;
      if (px_q == EDGE_MAX) py_q <= py_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_px_q    <= '0;
      s1_py_q    <= '0;
      hold_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= 1'b1;
      s1_first_q <= 1'b1;
      s1_px_q    <= px_q;
      s1_py_q    <= py_q;
    end else if (s1_valid_q && !Stall) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
    end else if (s1_valid_q && s1_first_q) begin
      hold_q     <= RomData;
      s1_first_q <= 1'b0;
    end
  end

endmodule
